muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide controller owning the HI/LO register pair; it sits beside the EXE stage and receives operands from the ID/EXE register. It sequences a shared shift-add/shift-subtract datapath over WIDTH cycles for MULT/MULTU/DIV/DIVU. It serves MFHI/MFLO/MTHI/MTLO accesses and raises a pipeline stall whenever an access collides with an operation in flight.

## Interface
- WIDTH, 32: operand width; iteration counter is clog2(WIDTH)+1 bits.
- CLOCK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- Start_IN  in  1  launch operation (EXE holds a mult/div instruction).
- Op_IN  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with Start_IN.
- OperandA_IN  in  WIDTH  rs value (multiplicand / dividend).
- OperandB_IN  in  WIDTH  rt value (multiplier / divisor).
- ReadHiLo_IN  in  1  MFHI/MFLO in EXE.
- ReadSelect_IN  in  1  0 = LO, 1 = HI.
- WriteHiLo_IN  in  1  MTHI/MTLO in EXE.
- WriteSelect_IN  in  1  0 = LO, 1 = HI.
- WriteData_IN  in  WIDTH  rs value for MTHI/MTLO.
- HiLoData_OUT  out  WIDTH  selected HI or LO, combinational from registers.
- Busy_OUT  out  1  operation in flight (state != IDLE).
- Stall_OUT  out  1  freeze IF/ID/EXE this cycle.
- DivByZero_OUT  out  1  sticky flag: last DIV/DIVU had divisor 0.

## Operation
- States: IDLE, MUL, DIV, FIXUP.
- IDLE: Start_IN=1 latches Op, |A| and |B| (magnitudes for signed ops, raw for unsigned), result signs, clears counter; goes to MUL or DIV. DIV/DIVU with B=0 goes straight to FIXUP.
- MUL: one shift-add step per cycle on 2*WIDTH accumulator; counter increments; after WIDTH steps -> FIXUP.
- DIV: one restoring shift-subtract step per cycle; after WIDTH steps -> FIXUP.
- FIXUP: negate product if signA^signB (signed mult); negate quotient if signA^signB, remainder if signA (signed div); write HI/LO; -> IDLE.
- Divide by zero: HI = OperandA as latched (unmodified), LO = all ones; DivByZero_OUT=1. Any later Start_IN accepted clears it.
- Signed overflow DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0; no flag.
- MTHI/MTLO in IDLE with no Start: write selected register at the edge.
- Stall_OUT = Busy_OUT & (Start_IN | ReadHiLo_IN | WriteHiLo_IN). Start while busy is ignored (EXE re-presents it after stall drops).
- Start and WriteHiLo in the same IDLE cycle: write applies, operation starts; result later overwrites both HI and LO.
- Reset values: HI=0, LO=0, state IDLE, Busy_OUT=0, Stall_OUT=0, DivByZero_OUT=0, HiLoData_OUT=0.
- RESET asserted mid-operation: abort immediately, all above reset values; no partial HI/LO write.

## Timing
- Start sampled at edge E0; iteration edges E1..E(WIDTH); FIXUP edge E(WIDTH+1) writes HI/LO.
- Busy_OUT high from after E0 through the cycle ending at E(WIDTH+1): WIDTH+1 cycles.
- MFHI/MFLO issued the cycle after completion reads new value with zero stall.
- Divide-by-zero: Busy for 1 cycle (FIXUP only).
- HiLoData_OUT, Stall_OUT combinational; all other state registered.

## Configuration
- MULDIV_EARLY_OUT_EN defined: in MUL, when the remaining unshifted multiplier bits are all zero, jump to FIXUP on the next edge (product already final); minimum MUL latency 1 step +FIXUP. Divide unchanged.
- Undefined: MUL always takes exactly WIDTH steps; latency fixed at WIDTH+1 cycles.

## Test plan
- MULT A=0xFFFFFFFD (-3), B=7, no early-out -> after 33 busy cycles HI=0xFFFFFFFF, LO=0xFFFFFFEB; Busy_OUT falls exactly at E33.
- DIVU A=100, B=7 -> LO=14, HI=2; DIV A=-100, B=7 -> LO=0xFFFFFFF2 (-14), HI=0xFFFFFFFE (-2).
- DIV A=0x12345678, B=0 -> 1 busy cycle, HI=0x12345678, LO=0xFFFFFFFF, DivByZero_OUT=1; next MULTU clears it.
- MFLO asserted 5 cycles into a MULT -> Stall_OUT high until completion, then HiLoData_OUT = new LO with Stall_OUT=0.
- MTHI 0xCAFEBABE with Start MULTU 2x3 same cycle -> HI reads 0xCAFEBABE during busy, then HI=0, LO=6.
- RESET low at E10 of a DIV -> HI=LO=0, Busy_OUT=0 immediately; with MULDIV_EARLY_OUT_EN, MULTU 5x1 completes in 2 cycles, LO=5.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair, with MFHI/MFLO/MTHI/MTLO access and stall.
// Optional build macro MULDIV_EARLY_OUT_EN: multiply finishes as soon as the remaining multiplier bits are zero.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             Start_IN,
    input  logic [1:0]       Op_IN,
    input  logic [WIDTH-1:0] OperandA_IN,
    input  logic [WIDTH-1:0] OperandB_IN,
    input  logic             ReadHiLo_IN,
    input  logic             ReadSelect_IN,
    input  logic             WriteHiLo_IN,
    input  logic             WriteSelect_IN,
    input  logic [WIDTH-1:0] WriteData_IN,
    output logic [WIDTH-1:0] HiLoData_OUT,
    output logic             Busy_OUT,
    output logic             Stall_OUT,
    output logic             DivByZero_OUT
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   W_ZERO   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   W_ONES   = {WIDTH{1'b1}};
    localparam logic [2*WIDTH-1:0] D_ZERO   = {(2*WIDTH){1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_MUL   = 2'b01,
        ST_DIV   = 2'b10,
        ST_FIXUP = 2'b11
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic               busy_r;
    logic               op_is_div_r;
    logic               neg_res_r;
    logic               neg_rem_r;
    logic               dbz_op_r;
    logic               dbz_flag_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] aux_r;
    logic [WIDTH-1:0]   mplier_r;
    logic [WIDTH-1:0]   raw_a_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;

    logic               idle_s;
    logic               start_acc_s;
    logic               is_signed_s;
    logic               sign_a_s;
    logic               sign_b_s;
    logic               div_by_zero_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic [WIDTH-1:0]   mplier_shift_s;
    logic [2*WIDTH-1:0] mul_sum_s;
    logic               mul_done_s;
    logic [WIDTH:0]     div_part_s;
    logic               div_ge_s;
    logic [WIDTH-1:0]   div_sub_s;
    logic [2*WIDTH-1:0] div_next_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quot_s;
    logic [WIDTH-1:0]   rem_s;
    logic [WIDTH-1:0]   fix_hi_s;
    logic [WIDTH-1:0]   fix_lo_s;

    assign idle_s        = (state_r == ST_IDLE);
    assign start_acc_s   = idle_s & Start_IN;
    assign is_signed_s   = ~Op_IN[0];
    assign sign_a_s      = is_signed_s & OperandA_IN[WIDTH-1];
    assign sign_b_s      = is_signed_s & OperandB_IN[WIDTH-1];
    assign mag_a_s       = sign_a_s ? (W_ZERO - OperandA_IN) : OperandA_IN;
    assign mag_b_s       = sign_b_s ? (W_ZERO - OperandB_IN) : OperandB_IN;
    assign div_by_zero_s = Op_IN[1] & (OperandB_IN == W_ZERO);

    // Multiply: add the left-shifting multiplicand whenever the current multiplier LSB is set.
    assign mplier_shift_s = {1'b0, mplier_r[WIDTH-1:1]};
    assign mul_sum_s      = mplier_r[0] ? (acc_r + aux_r) : acc_r;

`ifdef MULDIV_EARLY_OUT_EN
    assign mul_done_s = (cnt_r == CNT_LAST) | (mplier_shift_s == W_ZERO);
`else
    assign mul_done_s = (cnt_r == CNT_LAST);
`endif

    // Restoring divide: partial remainder needs one extra bit before the trial subtract.
    assign div_part_s = acc_r[2*WIDTH-1:WIDTH-1];
    assign div_ge_s   = (div_part_s >= {1'b0, aux_r[WIDTH-1:0]});
    assign div_sub_s  = div_part_s[WIDTH-1:0] - aux_r[WIDTH-1:0];
    assign div_next_s = div_ge_s ? {div_sub_s, acc_r[WIDTH-2:0], 1'b1}
                                 : {acc_r[2*WIDTH-2:0], 1'b0};

    assign prod_s = neg_res_r ? (D_ZERO - acc_r) : acc_r;
    assign quot_s = neg_res_r ? (W_ZERO - acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
    assign rem_s  = neg_rem_r ? (W_ZERO - acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];

    // Select the values written into HI/LO when the operation retires.
    always_comb begin
        fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
        fix_lo_s = prod_s[WIDTH-1:0];
        if (dbz_op_r) begin
            fix_hi_s = raw_a_r;
            fix_lo_s = W_ONES;
        end else if (op_is_div_r) begin
            fix_hi_s = rem_s;
            fix_lo_s = quot_s;
        end else begin
            fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
            fix_lo_s = prod_s[WIDTH-1:0];
        end
    end

    // Next-state logic of the sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!Start_IN) begin
                    state_nxt_s = ST_IDLE;
                end else if (!Op_IN[1]) begin
                    state_nxt_s = ST_MUL;
                end else if (div_by_zero_s) begin
                    state_nxt_s = ST_FIXUP;
                end else begin
                    state_nxt_s = ST_DIV;
                end
            end
            ST_MUL: begin
                if (mul_done_s) begin
                    state_nxt_s = ST_FIXUP;
                end else begin
                    state_nxt_s = ST_MUL;
                end
            end
            ST_DIV: begin
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_FIXUP;
                end else begin
                    state_nxt_s = ST_DIV;
                end
            end
            ST_FIXUP: state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // State register and registered busy indication.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
        end
    end

    // Operand capture and per-cycle iteration datapath.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            op_is_div_r <= 1'b0;
            neg_res_r   <= 1'b0;
            neg_rem_r   <= 1'b0;
            dbz_op_r    <= 1'b0;
            cnt_r       <= CNT_ZERO;
            acc_r       <= D_ZERO;
            aux_r       <= D_ZERO;
            mplier_r    <= W_ZERO;
            raw_a_r     <= W_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (Start_IN) begin
                        op_is_div_r <= Op_IN[1];
                        neg_res_r   <= sign_a_s ^ sign_b_s;
                        neg_rem_r   <= sign_a_s;
                        dbz_op_r    <= div_by_zero_s;
                        cnt_r       <= CNT_ZERO;
                        raw_a_r     <= OperandA_IN;
                        mplier_r    <= mag_b_s;
                        if (Op_IN[1]) begin
                            acc_r <= {W_ZERO, mag_a_s};
                            aux_r <= {W_ZERO, mag_b_s};
                        end else begin
                            acc_r <= D_ZERO;
                            aux_r <= {W_ZERO, mag_a_s};
                        end
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_MUL: begin
                    acc_r    <= mul_sum_s;
                    aux_r    <= {aux_r[2*WIDTH-2:0], 1'b0};
                    mplier_r <= mplier_shift_s;
                    cnt_r    <= cnt_r + CNT_ONE;
                end
                ST_DIV: begin
                    acc_r <= div_next_s;
                    cnt_r <= cnt_r + CNT_ONE;
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // HI/LO register pair: MTHI/MTLO only while idle, result write on retirement.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            hi_r <= W_ZERO;
            lo_r <= W_ZERO;
        end else if (idle_s && WriteHiLo_IN) begin
            if (WriteSelect_IN) begin
                hi_r <= WriteData_IN;
            end else begin
                lo_r <= WriteData_IN;
            end
        end else if (state_r == ST_FIXUP) begin
            hi_r <= fix_hi_s;
            lo_r <= fix_lo_s;
        end else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
        end
    end

    // Sticky divide-by-zero flag, cleared whenever a new operation is accepted.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            dbz_flag_r <= 1'b0;
        end else if (start_acc_s) begin
            dbz_flag_r <= 1'b0;
        end else if ((state_r == ST_FIXUP) && dbz_op_r) begin
            dbz_flag_r <= 1'b1;
        end else begin
            dbz_flag_r <= dbz_flag_r;
        end
    end

    assign HiLoData_OUT  = ReadSelect_IN ? hi_r : lo_r;
    assign Busy_OUT      = busy_r;
    assign Stall_OUT     = busy_r & (Start_IN | ReadHiLo_IN | WriteHiLo_IN);
    assign DivByZero_OUT = dbz_flag_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, hand-written pipeline sequences and
// randomized operations compared against an arithmetic reference model.
module tb_muldiv_unit;
    localparam int WIDTH = 32;

    logic              CLOCK = 1'b0;
    logic              RESET = 1'b0;
    logic              Start_IN = 1'b0;
    logic [1:0]        Op_IN = 2'b00;
    logic [WIDTH-1:0]  OperandA_IN = 32'h0;
    logic [WIDTH-1:0]  OperandB_IN = 32'h0;
    logic              ReadHiLo_IN = 1'b0;
    logic              ReadSelect_IN = 1'b0;
    logic              WriteHiLo_IN = 1'b0;
    logic              WriteSelect_IN = 1'b0;
    logic [WIDTH-1:0]  WriteData_IN = 32'h0;
    logic [WIDTH-1:0]  HiLoData_OUT;
    logic              Busy_OUT;
    logic              Stall_OUT;
    logic              DivByZero_OUT;

    int pass_cnt = 0;
    int check_cnt = 0;

    muldiv_unit #(.WIDTH(WIDTH)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .Start_IN(Start_IN), .Op_IN(Op_IN),
        .OperandA_IN(OperandA_IN), .OperandB_IN(OperandB_IN),
        .ReadHiLo_IN(ReadHiLo_IN), .ReadSelect_IN(ReadSelect_IN),
        .WriteHiLo_IN(WriteHiLo_IN), .WriteSelect_IN(WriteSelect_IN),
        .WriteData_IN(WriteData_IN), .HiLoData_OUT(HiLoData_OUT),
        .Busy_OUT(Busy_OUT), .Stall_OUT(Stall_OUT), .DivByZero_OUT(DivByZero_OUT)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        check_cnt++;
        if (actual === expected) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, actual, expected);
    endtask

    // Reference: {dbz, hi, lo} from plain integer arithmetic.
    function automatic logic [64:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sp;
        logic [63:0] up;
        int          sa;
        int          sb;
        logic [31:0] q;
        logic [31:0] r;
        sa = a;
        sb = b;
        case (op)
            2'b00: begin
                sp = longint'(sa) * longint'(sb);
                return {1'b0, 64'(sp)};
            end
            2'b01: begin
                up = {32'h0, a} * {32'h0, b};
                return {1'b0, up};
            end
            2'b10: begin
                if (b == 32'h0) return {1'b1, a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {1'b0, 32'h0, 32'h80000000};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, r, q};
            end
            default: begin
                if (b == 32'h0) return {1'b1, a, 32'hFFFFFFFF};
                return {1'b0, a % b, a / b};
            end
        endcase
    endfunction

    // Busy cycles expected for an operation.
    function automatic int exp_latency(input logic [1:0] op, input logic [31:0] b);
        logic [31:0] mag;
        int steps;
        if (op[1]) return (b == 32'h0) ? 1 : WIDTH + 1;
        mag = (!op[0] && b[31]) ? (32'h0 - b) : b;
        steps = WIDTH;
`ifdef MULDIV_EARLY_OUT_EN
        steps = 1;
        for (int i = 0; i < WIDTH; i++) if (mag[i]) steps = i + 1;
`else
        if (mag == 32'h0) steps = WIDTH;
`endif
        return steps + 1;
    endfunction

    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge CLOCK);
        Start_IN = 1'b1;
        Op_IN = op;
        OperandA_IN = a;
        OperandB_IN = b;
        @(negedge CLOCK);
        Start_IN = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (Busy_OUT === 1'b1 && cycles < 200) begin
            cycles++;
            @(negedge CLOCK);
        end
        if (cycles >= 200) begin
            check_cnt++;
            $display("FAIL timeout: Busy_OUT still high after %0d cycles", cycles);
        end
    endtask

    task automatic check_result(input string name, input logic [31:0] eh, input logic [31:0] el, input logic ed);
        ReadSelect_IN = 1'b1;
        #1;
        check({name, " HI"}, {32'h0, HiLoData_OUT}, {32'h0, eh});
        ReadSelect_IN = 1'b0;
        #1;
        check({name, " LO"}, {32'h0, HiLoData_OUT}, {32'h0, el});
        check({name, " dbz"}, {63'h0, DivByZero_OUT}, {63'h0, ed});
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input logic ed);
        int cycles;
        start_op(op, a, b);
        wait_done(cycles);
        check({name, " latency"}, 64'(cycles), 64'(exp_latency(op, b)));
        check_result(name, eh, el, ed);
    endtask

    initial begin
        logic [64:0] ref_v;
        int          cycles;
        int          stall_err;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs[0]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[1]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[2]  = '{2'b10, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0};
        vecs[3]  = '{2'b10, 32'h12345678, 32'h0,        32'h12345678, 32'hFFFFFFFF, 1'b1};
        vecs[4]  = '{2'b01, 32'd2,        32'd3,        32'h0,        32'd6,        1'b0};
        vecs[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0};
        vecs[6]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[7]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        1'b0};
        vecs[8]  = '{2'b11, 32'hFFFFFFFF, 32'd1,        32'h0,        32'hFFFFFFFF, 1'b0};
        vecs[9]  = '{2'b10, 32'd100,      32'hFFFFFFF9, 32'd2,        32'hFFFFFFF2, 1'b0};
        vecs[10] = '{2'b11, 32'd5,        32'h0,        32'd5,        32'hFFFFFFFF, 1'b1};
        vecs[11] = '{2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,        1'b0};
        vecs[12] = '{2'b00, 32'h0,        32'hFFFFFFFF, 32'h0,        32'h0,        1'b0};
        vecs[13] = '{2'b11, 32'd7,        32'd100,      32'd7,        32'd0,        1'b0};
        vecs[14] = '{2'b01, 32'd5,        32'd1,        32'h0,        32'd5,        1'b0};

        // Reset values
        #2;
        check("reset busy", {63'h0, Busy_OUT}, 64'h0);
        check("reset stall", {63'h0, Stall_OUT}, 64'h0);
        check_result("reset", 32'h0, 32'h0, 1'b0);
        @(negedge CLOCK);
        RESET = 1'b1;

        for (int i = 0; i < 15; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dbz);

        // MFLO five cycles into a MULT, plus a Start presented while busy
        ref_v = ref_model(2'b00, 32'h00012345, 32'h7FFFFFFF);
        start_op(2'b00, 32'h00012345, 32'h7FFFFFFF);
        repeat (4) @(negedge CLOCK);
        ReadHiLo_IN = 1'b1;
        ReadSelect_IN = 1'b0;
        #1;
        check("mflo stall", {63'h0, Stall_OUT}, 64'h1);
        @(negedge CLOCK);
        Start_IN = 1'b1;
        Op_IN = 2'b11;
        OperandA_IN = 32'd9;
        OperandB_IN = 32'd4;
        #1;
        check("start busy stall", {63'h0, Stall_OUT}, 64'h1);
        @(negedge CLOCK);
        Start_IN = 1'b0;
        stall_err = 0;
        cycles = 0;
        while (Busy_OUT === 1'b1 && cycles < 100) begin
            if (Stall_OUT !== 1'b1) stall_err++;
            cycles++;
            @(negedge CLOCK);
        end
        check("mflo seq finished", {63'h0, Busy_OUT}, 64'h0);
        check("stall held while busy", 64'(stall_err), 64'h0);
        check("stall after done", {63'h0, Stall_OUT}, 64'h0);
        check("mflo new LO", {32'h0, HiLoData_OUT}, {32'h0, ref_v[31:0]});
        ReadHiLo_IN = 1'b0;
        @(negedge CLOCK);
        check("busy start ignored", {63'h0, Busy_OUT}, 64'h0);
        check_result("mflo seq", ref_v[63:32], ref_v[31:0], 1'b0);

        // MTHI in the same cycle as Start MULTU 2x3
        @(negedge CLOCK);
        Start_IN = 1'b1;
        Op_IN = 2'b01;
        OperandA_IN = 32'd2;
        OperandB_IN = 32'd3;
        WriteHiLo_IN = 1'b1;
        WriteSelect_IN = 1'b1;
        WriteData_IN = 32'hCAFEBABE;
        @(negedge CLOCK);
        Start_IN = 1'b0;
        WriteHiLo_IN = 1'b0;
        ReadSelect_IN = 1'b1;
        #1;
        check("mthi during busy", {32'h0, HiLoData_OUT}, 64'hCAFEBABE);
        check("mthi busy", {63'h0, Busy_OUT}, 64'h1);
        wait_done(cycles);
        check_result("mthi+multu", 32'h0, 32'd6, 1'b0);

        // MTLO while idle
        @(negedge CLOCK);
        WriteHiLo_IN = 1'b1;
        WriteSelect_IN = 1'b0;
        WriteData_IN = 32'h13579BDF;
        @(negedge CLOCK);
        WriteHiLo_IN = 1'b0;
        check_result("mtlo idle", 32'h0, 32'h13579BDF, 1'b0);

        // Reset asserted at E10 of a DIV
        start_op(2'b10, 32'd1000, 32'd3);
        repeat (9) @(negedge CLOCK);
        ReadHiLo_IN = 1'b1;
        #4;
        RESET = 1'b0;
        #2;
        check("abort busy", {63'h0, Busy_OUT}, 64'h0);
        check("abort stall", {63'h0, Stall_OUT}, 64'h0);
        check_result("abort", 32'h0, 32'h0, 1'b0);
        @(negedge CLOCK);
        RESET = 1'b1;
        ReadHiLo_IN = 1'b0;
        run_op("post reset", 2'b11, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0);

        // Randomized operations against the reference model
        for (int n = 0; n < 40; n++) begin
            rop = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: rb = 32'hFFFFFFFF;
                2: rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            ra = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            ref_v = ref_model(rop, ra, rb);
            run_op($sformatf("rand%0d op%0d %h %h", n, rop, ra, rb), rop, ra, rb,
                   ref_v[63:32], ref_v[31:0], ref_v[64]);
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
